// File: rtl/video_stream_gen.sv
// video_stream_gen: programmable frame-timing source with selectable test patterns.
// Optional PIXEL_DIV2_EN: each active pixel spans two cycles (half-rate pixel clock).
module video_stream_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int VS_LEAD  = 16,
    parameter int VS_TAIL  = 16,
    parameter int F_GAP    = 64,
    parameter int CHK_BIT  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic [1:0] mode,
    input  logic [7:0] const_val,
    output logic       busy,
    output logic       frame_done,
    output logic       gen_frame_vsync,
    output logic       gen_frame_hsync,
    output logic       gen_frame_valid,
    output logic [7:0] gen_img_y
);

`ifdef PIXEL_DIV2_EN
    localparam int PX = 2;
`else
    localparam int PX = 1;
`endif
    localparam int HSPAN = H_ACTIVE * PX;
    localparam int LINE  = HSPAN + H_BLANK;
    localparam int CMX0  = (VS_LEAD > VS_TAIL) ? VS_LEAD : VS_TAIL;
    localparam int CMAX  = (CMX0 > F_GAP) ? CMX0 : F_GAP;
    localparam int HW    = (LINE > 1) ? $clog2(LINE) : 1;
    localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [2:0] {
        IDLE, LEAD, ACTIVE, TAIL, GAP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic [YW-1:0] y, y_n;
    logic          load;
    logic [1:0]    mode_q;
    logic [7:0]    cval_q;

    logic          vs_d, hs_d, valid_d, done_d, busy_d;
    logic [7:0]    pix_d, x8, y8;

    // State and counter registers; pattern controls latched at frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            hcnt   <= '0;
            y      <= '0;
            mode_q <= '0;
            cval_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            hcnt  <= hcnt_n;
            y     <= y_n;
            if (load) begin
                mode_q <= mode;
                cval_q <= const_val;
            end
        end
    end

    // Next-state and counter sequencing through the frame phases
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hcnt_n  = hcnt;
        y_n     = y;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !busy) begin
                    state_n = LEAD;
                    cnt_n   = '0;
                    load    = 1'b1;
                end
            end
            LEAD: begin
                if (cnt == CW'(VS_LEAD - 1)) begin
                    state_n = ACTIVE;
                    cnt_n   = '0;
                    hcnt_n  = '0;
                    y_n     = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ACTIVE: begin
                if (hcnt == HW'(LINE - 1)) begin
                    hcnt_n = '0;
                    if (y == YW'(V_ACTIVE - 1)) begin
                        state_n = TAIL;
                        y_n     = '0;
                        cnt_n   = '0;
                    end else begin
                        y_n = y + YW'(1);
                    end
                end else begin
                    hcnt_n = hcnt + HW'(1);
                end
            end
            TAIL: begin
                if (cnt == CW'(VS_TAIL - 1)) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            GAP: begin
                if (cnt == CW'(F_GAP - 1)) begin
                    cnt_n = '0;
                    if (continuous) begin
                        state_n = LEAD;
                        load    = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output decode from the current phase; registered below
    always_comb begin
        vs_d    = (state == LEAD) || (state == ACTIVE) || (state == TAIL);
        hs_d    = (state == ACTIVE) && (hcnt < HW'(HSPAN));
`ifdef PIXEL_DIV2_EN
        valid_d = hs_d && !hcnt[0];
`else
        valid_d = hs_d;
`endif
        done_d  = (state == TAIL) && (cnt == CW'(VS_TAIL - 1));
        busy_d  = (state != IDLE);
        x8      = 8'(hcnt >> (PX - 1));
        y8      = 8'(y);
        pix_d   = 8'h00;
        if (hs_d) begin
            unique case (mode_q)
                2'd0: pix_d = x8;
                2'd1: pix_d = y8;
                2'd2: pix_d = (x8[CHK_BIT] ^ y8[CHK_BIT]) ? 8'hFF : 8'h00;
                default: pix_d = cval_q;
            endcase
        end
    end

    // Registered stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            gen_frame_vsync <= 1'b0;
            gen_frame_hsync <= 1'b0;
            gen_frame_valid <= 1'b0;
            gen_img_y       <= 8'h00;
        end else begin
            busy            <= busy_d;
            frame_done      <= done_d;
            gen_frame_vsync <= vs_d;
            gen_frame_hsync <= hs_d;
            gen_frame_valid <= valid_d;
            gen_img_y       <= pix_d;
        end
    end

endmodule

// File: doc/video_stream_gen.md
Name: video_stream_gen

Overview:
- Frame-stream source that drives the vsync/hsync/valid/8-bit luma stream used by the image-processor chain. It is the transmit end of the interface that filter blocks consume on their pre_* inputs.
- Produces programmable frame timing plus a selectable test pattern. Used for standalone bring-up and for simulation stimulus of the filter pipeline.
- Single clock domain. Every output is registered.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- H_BLANK, 160, blank cycles per line after the active pixels (minimum 1).
- V_ACTIVE, 480, active lines per frame.
- VS_LEAD, 16, cycles with vsync high before the first line (minimum 1).
- VS_TAIL, 16, cycles with vsync high after the last line's blank (minimum 1).
- F_GAP, 64, cycles with vsync low between frames (minimum 1).
- CHK_BIT, 3, x/y bit that selects the checkerboard cell size.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a frame; ignored while busy=1.
- continuous  in  1  1 = loop frames until cleared; sampled at the end of F_GAP.
- mode  in  2  pattern: 0 = horizontal ramp, 1 = vertical ramp, 2 = checkerboard, 3 = constant.
- const_val  in  8  pixel value used in mode 3.
- busy  out  1  high from the cycle after start is accepted until the return to IDLE.
- frame_done  out  1  one-cycle pulse on the last VS_TAIL cycle.
- gen_frame_vsync  out  1  frame envelope.
- gen_frame_hsync  out  1  high during active pixels of a line.
- gen_frame_valid  out  1  pixel strobe.
- gen_img_y  out  8  pixel data; 0 whenever hsync=0.

Behaviour:
- Reset: state=IDLE; all outputs 0; all counters 0. Assertion mid-frame aborts immediately. After release the block waits for a new start.
- FSM states: IDLE, LEAD, ACTIVE, TAIL, GAP.
- IDLE to LEAD: start=1 at clock edge N. At edge N+1: vsync=1 and busy=1. mode and const_val are latched at this point and held for the whole frame.
- LEAD: lasts VS_LEAD cycles (vsync=1, hsync=0), then goes to ACTIVE.
- ACTIVE: V_ACTIVE lines. Each line is H_ACTIVE cycles with hsync=valid=1, followed by H_BLANK cycles with hsync=valid=0. Column counter x runs 0..H_ACTIVE-1; line counter y runs 0..V_ACTIVE-1. After the blank of line V_ACTIVE-1 the FSM goes to TAIL.
- TAIL: lasts VS_TAIL cycles with vsync=1. frame_done=1 on the final TAIL cycle. Then goes to GAP.
- GAP: lasts F_GAP cycles with vsync=0. On the last GAP cycle: continuous=1 goes to LEAD (re-latch mode/const_val); otherwise goes to IDLE and busy drops on the next edge.
- Pixel data, registered and aligned with hsync:
  - mode 0: x[7:0], wrapping modulo 256.
  - mode 1: y[7:0].
  - mode 2: 8'hFF if x[CHK_BIT]^y[CHK_BIT], else 8'h00.
  - mode 3: const_val.
- Frame length: total vsync-high cycles = VS_LEAD + V_ACTIVE*(H_ACTIVE+H_BLANK) + VS_TAIL.
- start arriving during busy has no effect. It is not queued.
- Counter widths are $clog2 of each maximum count (minimum 1 bit). No counter overflows at any legal parameter value.

Optional Feature:
- Macro: PIXEL_DIV2_EN.
- Defined: emulates a half-rate sensor pixel clock.
  - Each active pixel occupies 2 cycles; hsync is high for 2*H_ACTIVE cycles per line.
  - valid is high only on the first cycle of each pair.
  - gen_img_y is held for both cycles; x advances every 2 cycles.
  - Line length = 2*H_ACTIVE + H_BLANK, and the frame-length formula scales the same way.
- Undefined: valid == hsync, one pixel per cycle, as described under Behaviour.

Test Plan:
All scenarios use H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VS_LEAD=3, VS_TAIL=2, F_GAP=5, CHK_BIT=1.
1. start pulse with mode=0, continuous=0 -> vsync high exactly 53 cycles, then 5 low cycles, then busy=0. 4 hsync pulses of 8 cycles each; y data 0..7 on each line; one frame_done pulse.
2. mode=1 -> line k outputs 8 pixels of value k (k=0..3); gen_img_y=0 during all blank cycles.
3. mode=2 -> line 0 outputs 00,00,FF,FF,00,00,FF,FF; line 2 outputs FF,FF,00,00,FF,FF,00,00.
4. mode=3, const_val=8'hA5, continuous=1 -> back-to-back frames at a 58-cycle period. Changing mode mid-frame takes effect only from the next frame. Clearing continuous gives one final frame, then IDLE.
5. start asserted again during a frame, then rst_n pulsed low mid-ACTIVE -> the extra start is ignored. All outputs go to 0 asynchronously; no activity after release until a new start.
6. With PIXEL_DIV2_EN defined, mode=0 -> hsync high 16 cycles per line; valid toggles 1,0,…; pixels 0..7 each held 2 cycles; vsync high for 3 + 4*20 + 2 = 85 cycles.
